rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Parametrised round-robin arbiter granting one of N_REQ requesters exclusive ownership
//  of a shared resource (bus, UART, SPI flash port) in the picosoc fabric. Next generation
//  of the fixed 8-bit byte arbiter: width-generic, fair rotating priority, request/grant/done
//  handshake with grant held across multi-cycle transfers, optional hold-timeout watchdog.
// PARAMETERS
//  N_REQ     8    number of requesters (2..32)
//  MAX_HOLD  255  max cycles a grant may be held before forced release (timeout build only)
//  HOLD_W    8    width of hold counter; MAX_HOLD must fit in HOLD_W bits
//  ID_W      3    localparam = $clog2(N_REQ), width of gnt_id
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  req        in   N_REQ  request vector, bit i = requester i wants the resource
//  done       in   1      current owner finished; honoured only while gnt_valid=1
//  gnt        out  N_REQ  one-hot grant, registered
//  gnt_valid  out  1      1 while any grant is active
//  gnt_id     out  ID_W   binary index of granted requester (valid when gnt_valid=1)
//  timeout    out  1      1-cycle pulse when watchdog forces a release
// BEHAVIOUR
//  - Reset (rst=1 at edge): gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0, state=IDLE.
//    Reset mid-grant drops grant on that same edge; no done required.
//  - State IDLE: if |req, winner = first set bit scanning ptr, ptr+1, ... wrapping at N_REQ-1->0.
//    Next edge: gnt=1<<winner, gnt_id=winner, gnt_valid=1, state=GRANT. Latency req->gnt = 1 cycle.
//    If req==0: remain IDLE, outputs 0.
//  - State GRANT: gnt/gnt_id held constant; req changes ignored (owner dropping req keeps grant).
//    done=1 at edge: gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod N_REQ, state=IDLE.
//    One bubble cycle between consecutive grants (IDLE re-arbitrates next edge).
//  - done while IDLE is ignored. Owner is lowest-priority for next arbitration (fairness);
//    any continuously requesting input is granted within N_REQ grants.
//  - ptr wrap: gnt_id=N_REQ-1 released -> ptr=0.
//  - gnt is always one-hot or zero; gnt_id=0 whenever gnt_valid=0.
// CONFIGURATION
//  RR_ARBITER_TIMEOUT_EN defined:
//   - HOLD_W-bit counter cleared on entry to GRANT, +1 each GRANT cycle without done.
//   - When counter==MAX_HOLD-1 and done=0: release exactly as done (ptr advance, IDLE),
//     timeout=1 for that one following cycle. done and expiry same cycle -> normal release,
//     timeout stays 0.
//  RR_ARBITER_TIMEOUT_EN undefined:
//   - no counter; grant held indefinitely until done or rst; timeout tied 0.
// TESTING
//  1 rst=1 two cycles, req=8'hFF -> gnt=0, gnt_valid=0, gnt_id=0, timeout=0 throughout.
//  2 after reset req=8'b0000_0101 -> next cycle gnt=8'h01,gnt_id=0; pulse done ->
//    gnt=0 one cycle, then gnt=8'h04,gnt_id=2.
//  3 req=8'hFF held, done pulsed each grant -> gnt_id sequence 0,1,2,...,7,0 (wrap), one idle
//    cycle between each.
//  4 req0 granted, req drops to 0 for 5 cycles, no done -> gnt=8'h01 held; done -> release.
//  5 grant active on id 3, rst=1 one cycle -> gnt=0 next edge; then req=8'hFF -> gnt_id=0.
//  6 TIMEOUT_EN, MAX_HOLD=4, req=8'h03, no done -> gnt=8'h01 for 4 cycles, release, timeout=1
//    one cycle, then gnt=8'h02,gnt_id=1; without macro gnt=8'h01 held for 100 cycles.

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with held grants; optional watchdog via RR_ARBITER_TIMEOUT_EN
module rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic [ID_W-1:0] next_ptr;

`ifdef RR_ARBITER_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              expire;

  assign expire = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  logic unused_cfg;

  assign unused_cfg = MAX_HOLD[0] ^ HOLD_W[0];
`endif

  // Pick the first requester at or after ptr, wrapping N_REQ-1 -> 0.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // The releasing owner becomes lowest priority for the next round.
  always_comb begin
    next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Arbitration state machine; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            state     <= GRANT;
`ifdef RR_ARBITER_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (done) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= next_ptr;
            state     <= IDLE;
`ifdef RR_ARBITER_TIMEOUT_EN
          end else if (expire) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= next_ptr;
            state     <= IDLE;
            timeout   <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter (table, corner sequences, random vs model)
module tb_rr_arbiter;

  localparam int N = 8;
`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int  MH     = 4;
  localparam bit  TO_EN  = 1'b1;
`else
  localparam int  MH     = 255;
  localparam bit  TO_EN  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, where the rotation starts, how long held.
  int m_owner = -1;
  int m_start = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_step(input bit r, input logic [N-1:0] q, input bit d);
    if (r) begin
      m_owner = -1; m_start = 0; m_held = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      m_to = 1'b0;
      if (d) begin
        m_start = (m_owner + 1) % N; m_owner = -1;
      end else if (TO_EN && (m_held + 1 >= MH)) begin
        m_start = (m_owner + 1) % N; m_owner = -1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && q[(m_start + k) % N]) begin
          m_owner = (m_start + k) % N;
          m_held  = 0;
        end
      end
    end
  endtask

  task automatic tick(input bit r, input logic [N-1:0] q, input bit d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [N-1:0] eg, input int eid, input bit ev, input bit et);
    chk({name, ".gnt"}, 32'(gnt), 32'(eg));
    chk({name, ".gnt_id"}, 32'(gnt_id), 32'(eid));
    chk({name, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
    chk({name, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  typedef struct {
    bit           r;
    logic [N-1:0] q;
    bit           d;
    logic [N-1:0] eg;
    int           eid;
    bit           ev;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 0, 1'b0};
    vecs[2]  = '{1'b0, 8'h05, 1'b0, 8'h01, 0, 1'b1};
    vecs[3]  = '{1'b0, 8'h05, 1'b1, 8'h00, 0, 1'b0};
    vecs[4]  = '{1'b0, 8'h05, 1'b0, 8'h04, 2, 1'b1};
    vecs[5]  = '{1'b0, 8'h05, 1'b1, 8'h00, 0, 1'b0};
    vecs[6]  = '{1'b0, 8'h05, 1'b0, 8'h01, 0, 1'b1};
    vecs[7]  = '{1'b0, 8'h05, 1'b1, 8'h00, 0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h00, 0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0};
    vecs[10] = '{1'b0, 8'h80, 1'b0, 8'h80, 7, 1'b1};
    vecs[11] = '{1'b0, 8'h80, 1'b1, 8'h00, 0, 1'b0};
    vecs[12] = '{1'b0, 8'h82, 1'b0, 8'h02, 1, 1'b1};

    rst = 1'b1; req = '0; done = 1'b0;
    #2;

    // Table: reset behaviour, basic grant/release, pointer rotation and wrap, done while idle.
    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].q, vecs[i].d);
      chk_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eid, vecs[i].ev, 1'b0);
    end

    // All requesting: ids rotate 0..7 then wrap to 0, idle bubble after each release.
    tick(1'b1, 8'h00, 1'b0);
    for (int k = 0; k <= N; k++) begin
      tick(1'b0, 8'hFF, 1'b0);
      chk_out($sformatf("rot%0d", k), 8'(1 << (k % N)), k % N, 1'b1, 1'b0);
      tick(1'b0, 8'hFF, 1'b1);
      chk_out($sformatf("rot_bubble%0d", k), 8'h00, 0, 1'b0, 1'b0);
    end

    // Owner drops its request: grant is held until done.
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b0, 8'h01, 1'b0);
    chk_out("hold_start", 8'h01, 0, 1'b1, 1'b0);
    for (int k = 0; k < (TO_EN ? 2 : 5); k++) begin
      tick(1'b0, 8'h00, 1'b0);
      chk_out($sformatf("hold%0d", k), 8'h01, 0, 1'b1, 1'b0);
    end
    tick(1'b0, 8'h00, 1'b1);
    chk_out("hold_release", 8'h00, 0, 1'b0, 1'b0);

    // Reset mid-grant drops the grant and returns the pointer to 0.
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b0, 8'h04, 1'b0);
    tick(1'b0, 8'h04, 1'b1);
    tick(1'b0, 8'h08, 1'b0);
    chk_out("mid_id3", 8'h08, 3, 1'b1, 1'b0);
    tick(1'b1, 8'hFF, 1'b0);
    chk_out("mid_rst", 8'h00, 0, 1'b0, 1'b0);
    tick(1'b0, 8'hFF, 1'b0);
    chk_out("mid_after", 8'h01, 0, 1'b1, 1'b0);

    // Watchdog: forced release after MAX_HOLD cycles, or indefinite hold without it.
    tick(1'b1, 8'h00, 1'b0);
    if (TO_EN) begin
      for (int k = 0; k < MH; k++) begin
        tick(1'b0, 8'h03, 1'b0);
        chk_out($sformatf("wd_hold%0d", k), 8'h01, 0, 1'b1, 1'b0);
      end
      tick(1'b0, 8'h03, 1'b0);
      chk_out("wd_expire", 8'h00, 0, 1'b0, 1'b1);
      tick(1'b0, 8'h03, 1'b0);
      chk_out("wd_next", 8'h02, 1, 1'b1, 1'b0);
      // done coinciding with expiry is an ordinary release
      for (int k = 0; k < MH - 1; k++) tick(1'b0, 8'h03, 1'b0);
      tick(1'b0, 8'h03, 1'b1);
      chk_out("wd_done_same", 8'h00, 0, 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < 100; k++) begin
        tick(1'b0, 8'h03, 1'b0);
        chk_out($sformatf("nowd%0d", k), 8'h01, 0, 1'b1, 1'b0);
      end
      tick(1'b0, 8'h03, 1'b1);
      chk_out("nowd_release", 8'h00, 0, 1'b0, 1'b0);
    end

    // Random traffic against the reference model.
    tick(1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] q;
      bit r, d;
      r = ($urandom_range(0, 149) == 0);
      q = ($urandom_range(0, 1) == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      d = ($urandom_range(0, 3) == 0);
      tick(r, q, d);
      chk_out($sformatf("rnd%0d", c), (m_owner >= 0) ? N'(1 << m_owner) : N'(0),
              (m_owner >= 0) ? m_owner : 0, (m_owner >= 0), m_to);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
